// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Produces pixel/line
//             counters plus sync, blanking, data-enable, strobes and a frame
//             counter, all registered and aligned to the counts they describe.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CE_DIV    = 1,
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               pix_tick,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG   = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG   = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int PRE_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CE_DIV - 1);

  // Reject modes whose counters cannot hold their last position.
  generate
    if (H_TOTAL - 1 >= 2 ** CNT_W) begin : g_bad_h_width
      $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
    end
    if (V_TOTAL - 1 >= 2 ** CNT_W) begin : g_bad_v_width
      $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
    end
    if (CE_DIV < 1) begin : g_bad_ce_div
      $error("vga_timing_gen: CE_DIV must be at least 1");
    end
  endgenerate

  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic             h_last;
  logic             v_last;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;

  // Next raster position; outputs are decoded from it so they land with it.
  always_comb begin
    tick   = en && (prescaler == PRE_LAST);
    h_last = (hcount == H_LAST);
    v_last = (vcount == V_LAST);
    h_nxt  = h_last ? '0 : hcount + CNT_W'(1);
    v_nxt  = vcount;
    if (h_last) begin
      v_nxt = v_last ? '0 : vcount + CNT_W'(1);
    end
  end

  // Pixel-clock-enable divider; dropping en restarts the divide period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (!en || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Counters and level decodes advance only on a tick, otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount    <= '0;
      vcount    <= '0;
      hblnk     <= 1'b0;
      vblnk     <= 1'b0;
      de        <= 1'b1;
      hsync     <= ~HSYNC_POL;
      vsync     <= ~VSYNC_POL;
      frame_cnt <= '0;
    end else if (tick) begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      hblnk  <= (int'(h_nxt) >= H_ACTIVE);
      vblnk  <= (int'(v_nxt) >= V_ACTIVE);
      de     <= (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      hsync  <= ((int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync  <= ((int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      if (h_last && v_last) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Single-cycle strobes; they are only ever set by a tick, so en=0 clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_tick <= 1'b0;
      sof      <= 1'b0;
      eol      <= 1'b0;
    end else begin
      pix_tick <= tick;
      sof      <= tick && (h_nxt == '0) && (v_nxt == '0);
      eol      <= tick && (h_nxt == H_LAST);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen using a reduced raster
//             (16 x 10 positions). A cycle model feeds a scoreboard queue per
//             instance; directed steps cover polarity, divider, freeze, async
//             reset and frame counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int CW = 5;

  typedef struct {
    int pre;
    int h;
    int v;
    int f;
    bit pt;
    bit sof;
    bit eol;
  } model_t;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          hs;
    logic          vs;
    logic          hb;
    logic          vb;
    logic          de;
    logic          pt;
    logic          sof;
    logic          eol;
    logic [3:0]    f;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic [CW-1:0] h0, v0, h1, v1;
  logic hs0, vs0, hb0, vb0, de0, pt0, sof0, eol0;
  logic hs1, vs1, hb1, vb1, de1, pt1, sof1, eol1;
  logic [1:0] f0;
  logic [3:0] f1;

  int errors = 0;
  int checks = 0;

  model_t m0, m1;
  obs_t   q0[$];
  obs_t   q1[$];

  always #5 clk = ~clk;

  // Instance 0: positive syncs, every-cycle pixel, 2-bit frame counter.
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CE_DIV(1), .CNT_W(CW), .FRAME_W(2)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en),
    .hcount(h0), .vcount(v0), .hsync(hs0), .vsync(vs0),
    .hblnk(hb0), .vblnk(vb0), .de(de0), .pix_tick(pt0),
    .sof(sof0), .eol(eol0), .frame_cnt(f0)
  );

  // Instance 1: negative syncs, pixel every 3rd cycle.
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CE_DIV(3), .CNT_W(CW), .FRAME_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en),
    .hcount(h1), .vcount(v1), .hsync(hs1), .vsync(vs1),
    .hblnk(hb1), .vblnk(vb1), .de(de1), .pix_tick(pt1),
    .sof(sof1), .eol(eol1), .frame_cnt(f1)
  );

  function automatic model_t model_reset();
    model_t m;
    m.pre = 0; m.h = 0; m.v = 0; m.f = 0;
    m.pt = 1'b0; m.sof = 1'b0; m.eol = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit en_i, int ce, int fmod);
    model_t n = m;
    n.pt = 1'b0; n.sof = 1'b0; n.eol = 1'b0;
    if (!en_i) begin
      n.pre = 0;
    end else if (m.pre == ce - 1) begin
      n.pre = 0;
      n.h   = m.h + 1;
      if (n.h == HT) begin
        n.h = 0;
        n.v = m.v + 1;
        if (n.v == VT) begin
          n.v = 0;
          n.f = (m.f + 1) % fmod;
        end
      end
      n.pt  = 1'b1;
      n.sof = (n.h == 0) && (n.v == 0);
      n.eol = (n.h == HT - 1);
    end else begin
      n.pre = m.pre + 1;
    end
    return n;
  endfunction

  function automatic obs_t model_out(model_t m, bit hp, bit vp);
    obs_t o;
    o.h   = CW'(m.h);
    o.v   = CW'(m.v);
    o.hb  = (m.h >= HA);
    o.vb  = (m.v >= VA);
    o.de  = (m.h < HA) && (m.v < VA);
    o.hs  = (m.h >= HA + HF && m.h < HA + HF + HS) ? hp : ~hp;
    o.vs  = (m.v >= VA + VF && m.v < VA + VF + VS) ? vp : ~vp;
    o.pt  = m.pt;
    o.sof = m.sof;
    o.eol = m.eol;
    o.f   = 4'(m.f);
    return o;
  endfunction

  // Scoreboard: expected state pushed at each edge, popped against the DUT 1 ns later.
  always @(posedge clk) begin
    obs_t e0, e1, a0, a1;
    if (rst) begin
      m0 = model_reset();
      m1 = model_reset();
    end else begin
      m0 = model_step(m0, en, 1, 4);
      m1 = model_step(m1, en, 3, 16);
    end
    q0.push_back(model_out(m0, 1'b1, 1'b1));
    q1.push_back(model_out(m1, 1'b0, 1'b0));
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    a0 = '{h0, v0, hs0, vs0, hb0, vb0, de0, pt0, sof0, eol0, {2'b00, f0}};
    a1 = '{h1, v1, hs1, vs1, hb1, vb1, de1, pt1, sof1, eol1, f1};
    checks++;
    assert (a0 === e0) else begin
      errors++;
      $error("FAIL sb_dut0 observed=%h expected=%h", a0, e0);
    end
    checks++;
    assert (a1 === e1) else begin
      errors++;
      $error("FAIL sb_dut1 observed=%h expected=%h", a1, e1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sof0(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #2;
      if (sof0 === 1'b1) found = 1'b1;
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
  endtask

  initial begin
    int cnt_hs, cnt_hb, cnt_eol, cnt_sof, cnt_vs, cnt_vb, cnt_pt;
    bit found, hold_ok, strobe_seen;
    logic [CW-1:0] v_frozen;

    // Reset state
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_h0", 32'(h0), 0);
    chk("rst_v0", 32'(v0), 0);
    chk("rst_de0", 32'(de0), 1);
    chk("rst_hsync0", 32'(hs0), 0);
    chk("rst_vsync0", 32'(vs0), 0);
    chk("rst_strobes0", 32'({pt0, sof0, eol0}), 0);
    chk("rst_frame0", 32'(f0), 0);
    chk("rst_hsync1_neg", 32'(hs1), 1);
    chk("rst_vsync1_neg", 32'(vs1), 1);

    // First line of dut0: sync, blanking and eol counts over one full line
    @(negedge clk);
    rst = 1'b0;
    cnt_hs = 0; cnt_hb = 0; cnt_eol = 0; cnt_sof = 0;
    repeat (HT) begin
      @(posedge clk); #2;
      if (hs0 === 1'b1) begin
        cnt_hs++;
        chk("hsync_window", 32'((h0 >= 10) && (h0 <= 12)), 1);
      end
      if (hb0 === 1'b1) cnt_hb++;
      if (eol0 === 1'b1) cnt_eol++;
      if (sof0 === 1'b1) cnt_sof++;
    end
    chk("line_hsync_cycles", 32'(cnt_hs), 3);
    chk("line_hblnk_cycles", 32'(cnt_hb), 8);
    chk("line_eol_count", 32'(cnt_eol), 1);
    chk("line_no_sof", 32'(cnt_sof), 0);

    // End of first frame: wraps coincide with sof, de back on
    wait_sof0("sof1");
    chk("sof1_pos", 32'({h0, v0}), 0);
    chk("sof1_frame", 32'(f0), 1);
    chk("sof1_de", 32'({de0, hb0, vb0}), 3'b100);

    // One whole frame: vertical sync/blank extents and a single sof
    cnt_vs = 0; cnt_vb = 0; cnt_sof = 0;
    repeat (HT * VT) begin
      @(posedge clk); #2;
      if (vs0 === 1'b1) cnt_vs++;
      if (vb0 === 1'b1) cnt_vb++;
      if (sof0 === 1'b1) cnt_sof++;
    end
    chk("frame_vsync_cycles", 32'(cnt_vs), 2 * HT);
    chk("frame_vblnk_cycles", 32'(cnt_vb), 4 * HT);
    chk("frame_sof_count", 32'(cnt_sof), 1);
    chk("frame2_cnt", 32'(f0), 2);

    // Two-bit frame counter wraps 3 -> 0 on the fourth sof
    wait_sof0("sof3");
    chk("frame3_cnt", 32'(f0), 3);
    wait_sof0("sof4");
    chk("frame_wrap_cnt", 32'(f0), 0);

    // Divided instance: one pixel per 3 clocks, one eol per line period
    cnt_pt = 0; cnt_eol = 0;
    repeat (3 * HT) begin
      @(posedge clk); #2;
      if (pt1 === 1'b1) cnt_pt++;
      if (eol1 === 1'b1) cnt_eol++;
    end
    chk("div_pix_ticks", 32'(cnt_pt), HT);
    chk("div_eol_count", 32'(cnt_eol), 1);

    // Freeze at hcount=5 for 37 cycles
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (h0 === CW'(5)) found = 1'b1;
    end
    chk("freeze_found", 32'(found), 1);
    v_frozen = v0;
    en = 1'b0;
    hold_ok = 1'b1;
    strobe_seen = 1'b0;
    repeat (37) begin
      @(posedge clk); #2;
      if (h0 !== CW'(5) || v0 !== v_frozen) hold_ok = 1'b0;
      if (sof0 === 1'b1 || eol0 === 1'b1 || pt0 === 1'b1) strobe_seen = 1'b1;
    end
    chk("freeze_hold", 32'(hold_ok), 1);
    chk("freeze_no_strobe", 32'(strobe_seen), 0);
    en = 1'b1;
    @(posedge clk); #2;
    chk("resume_h0", 32'(h0), 6);
    chk("resume_tick0", 32'(pt0), 1);

    // Asynchronous reset between edges at (700-equivalent) hcount=7, vcount=3
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #2;
      if (h0 === CW'(7) && v0 === CW'(3)) found = 1'b1;
    end
    chk("areset_found", 32'(found), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_pos0", 32'({h0, v0}), 0);
    chk("areset_de0", 32'(de0), 1);
    chk("areset_syncs0", 32'({hs0, vs0}), 0);
    chk("areset_syncs1", 32'({hs1, vs1}), 2'b11);
    chk("areset_frame1", 32'(f1), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_h1_c1", 32'(h1), 0);
    chk("post_rst_h0_c1", 32'(h0), 1);
    @(posedge clk); #2;
    chk("post_rst_h1_c2", 32'(h1), 0);
    @(posedge clk); #2;
    chk("post_rst_h1_c3", 32'(h1), 1);
    chk("post_rst_tick1", 32'(pt1), 1);

    repeat (10) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
